cdc_word_launch: RTL and testbench

CDC_WORD_LAUNCH -- requirements
Module: cdc_word_launch

---
 rtl/cdc_word_launch_pkg.sv | 27 ++
 rtl/sync_1bit.sv | 23 ++
 rtl/cdc_word_launch.sv | 127 ++++++++++++
 tb/tb_cdc_word_launch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_word_launch_pkg.sv
// rtl/cdc_word_launch_pkg.sv - shared CDC state encoding and constants for the word launcher
package cdc_word_launch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } cdc_state_t;

    // Cycles beyond the synchronizer depth to wait after reset before trusting ack_s.
    localparam int SETTLE_MARGIN = 1;

    function automatic int settle_cycles(input int n_sync);
        return n_sync + SETTLE_MARGIN;
    endfunction

    // Bits needed to hold max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_1bit.sv
// rtl/sync_1bit.sv - standard 1-bit multi-stage synchronizer cell
module sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N_STAGES-2:0], d};
        end
    end

    assign q = stages[N_STAGES-1];

endmodule

// File: rtl/cdc_word_launch.sv
// rtl/cdc_word_launch.sv - four-phase launcher of one held word into a remote clock domain
module cdc_word_launch
    import cdc_word_launch_pkg::*;
#(
    parameter int W_DATA  = 32,
    parameter int N_SYNC  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [W_DATA-1:0] in_data,
    output logic              out_req,
    output logic [W_DATA-1:0] out_data,
    input  logic              out_ack,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam int PH_W   = cnt_width(TIMEOUT);
    localparam int SETTLE = settle_cycles(N_SYNC);
    localparam int ST_W   = cnt_width(SETTLE);

    localparam logic [PH_W-1:0] PH_MAX   = '1;
    localparam logic [PH_W-1:0] PH_PRE   = PH_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [ST_W-1:0] SETTLE_V = ST_W'(SETTLE);

    cdc_state_t      state;
    cdc_state_t      state_next;
    logic            ack_s;
    logic            accept;
    logic            phase_run;
    logic            timeout_evt;
    logic            settle_done;
    logic [PH_W-1:0] phase_cnt;
    logic [ST_W-1:0] settle_cnt;

    sync_1bit #(
        .N_STAGES(N_SYNC)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (out_ack),
        .q  (ack_s)
    );

    assign in_rdy      = !rst && (state == ST_IDLE) && !ack_s;
    assign busy        = rst || (state != ST_IDLE);
    assign accept      = in_vld && in_rdy;
    assign settle_done = (settle_cnt == SETTLE_V);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // After reset a stale remote ack needs time to reach ack_s.
                if (settle_done && !ack_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_RELEASE;
            end
        endcase
    end

    assign phase_run   = (state != ST_IDLE) && (state_next == state);
    assign timeout_evt = (TIMEOUT != 0) && phase_run && (phase_cnt == PH_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RELEASE;
            out_req <= 1'b0;
        end else begin
            state   <= state_next;
            out_req <= (state_next == ST_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (accept) begin
            out_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (!phase_run) begin
                phase_cnt <= '0;
            end else if (phase_cnt != PH_MAX) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if (!settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout_evt) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_word_launch.sv
// tb/tb_cdc_word_launch.sv - self-checking bench for cdc_word_launch
module tb_cdc_word_launch;

    localparam int W  = 32;
    localparam int NS = 2;
    localparam int TO = 8;
    localparam int RT = 2 * NS + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] in_data = '0;
    logic         out_req;
    logic [W-1:0] out_data;
    logic         out_ack = 1'b0;
    logic         busy;
    logic         err;
    logic         err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [NS-1:0] ack_hist = '0;
    logic          remote_on = 1'b0;
    int            dly_lo = 0;
    int            dly_hi = 0;
    int            dly = 0;
    int            wcnt = 0;
    logic [W-1:0]  rx_q[$];
    logic [W-1:0]  exp_q[$];

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] data;
        logic         ack;
        logic         e_rdy;
        logic         e_req;
        logic         e_busy;
        logic         e_err;
        logic [W-1:0] e_data;
    } vec_t;

    vec_t         tbl[15];
    logic [W-1:0] words[3];
    int           acc_cyc[3];
    int           idx;
    int           cnt;
    int           sent;
    int           recvd;
    logic         acc;
    logic         p_req;
    logic         p_acks;
    logic [W-1:0] p_data;
    logic [W-1:0] got;

    cdc_word_launch #(
        .W_DATA (W),
        .N_SYNC (NS),
        .TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .out_req (out_req),
        .out_data(out_data),
        .out_ack (out_ack),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remote side: answers each req/ack disagreement after a random delay.
    task automatic remote();
        if (out_req != out_ack) begin
            if (wcnt >= dly) begin
                if (out_req) rx_q.push_back(out_data);
                out_ack = out_req;
                wcnt = 0;
                dly = $urandom_range(dly_hi, dly_lo);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    // Synchronizer modelled as a pure delay line of the ack seen at each edge.
    task automatic step();
        @(posedge clk);
        if (rst) ack_hist = '0;
        else ack_hist = {ack_hist[NS-2:0], out_ack};
        cyc++;
        #1;
        if (remote_on) remote();
    endtask

    initial begin
        // rst vld data ack | rdy req busy err data
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 1'b1, 32'h87654321, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

        // Reset release and a single hand-acked transfer.
        for (int i = 0; i < 15; i++) begin
            rst     = tbl[i].rst;
            in_vld  = tbl[i].vld;
            in_data = tbl[i].data;
            out_ack = tbl[i].ack;
            step();
            chk($sformatf("row%0d_in_rdy", i), in_rdy, tbl[i].e_rdy);
            chk($sformatf("row%0d_out_req", i), out_req, tbl[i].e_req);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("row%0d_out_data", i), out_data, tbl[i].e_data);
        end
        in_vld = 1'b0;

        // Three words behind a held in_vld with an instant-ack remote.
        rx_q.delete();
        remote_on = 1'b1;
        dly_lo = 0;
        dly_hi = 0;
        dly = 0;
        wcnt = 0;
        words[0] = 32'h1;
        words[1] = 32'h2;
        words[2] = 32'h3;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        acc_cyc[2] = 0;
        idx = 0;
        in_vld = 1'b1;
        in_data = words[0];
        for (int t = 0; t < 100 && idx < 3; t++) begin
            acc = in_rdy;
            if (acc) acc_cyc[idx] = cyc;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) in_data = words[idx];
                else in_vld = 1'b0;
            end
        end
        in_vld = 1'b0;
        chk("burst_accepted", idx, 3);
        chk("burst_spacing_01", acc_cyc[1] - acc_cyc[0], RT);
        chk("burst_spacing_12", acc_cyc[2] - acc_cyc[1], RT);
        for (int t = 0; t < 100 && busy; t++) step();
        chk("burst_idle", busy, 0);
        chk("burst_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (rx_q.size() > 0) chk($sformatf("burst_word%0d", i), rx_q.pop_front(), words[i]);
        end
        remote_on = 1'b0;

        // Timeout with ack stuck low; err_clr coincident with the timeout.
        out_ack = 1'b0;
        chk("to_err_before", err, 0);
        chk("to_rdy_before", in_rdy, 1);
        in_vld = 1'b1;
        in_data = 32'hA5A5A5A5;
        step();
        in_vld = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            err_clr = (k == TO);
            step();
            chk($sformatf("to_err_k%0d", k), err, (k == TO) ? 1 : 0);
            chk($sformatf("to_req_k%0d", k), out_req, 1);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_err_cleared", err, 0);
        out_ack = 1'b1;
        for (int t = 0; t < 20 && out_req; t++) step();
        chk("to_req_dropped", out_req, 0);
        out_ack = 1'b0;
        for (int t = 0; t < 20 && busy; t++) step();
        chk("to_idle", busy, 0);

        // Reset pulsed while the remote ack is high.
        in_vld = 1'b1;
        in_data = 32'h5555AAAA;
        step();
        in_vld = 1'b0;
        out_ack = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("mr_out_req", out_req, 0);
        chk("mr_in_rdy", in_rdy, 0);
        chk("mr_out_data", out_data, 0);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            chk($sformatf("mr_hold_rdy%0d", t), in_rdy, 0);
            chk($sformatf("mr_hold_req%0d", t), out_req, 0);
        end
        out_ack = 1'b0;
        cnt = 0;
        while (!in_rdy && cnt < 50) begin
            step();
            cnt++;
        end
        chk("mr_rdy_at_least_2", (cnt >= 2) ? 1 : 0, 1);
        chk("mr_rdy_delay", cnt, NS + 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Random ack delays against a scoreboard.
        rx_q.delete();
        exp_q.delete();
        remote_on = 1'b1;
        dly_lo = 0;
        dly_hi = 50;
        dly = $urandom_range(50, 0);
        wcnt = 0;
        sent = 0;
        recvd = 0;
        for (int t = 0; t < 90000; t++) begin
            if (sent >= 1000 && recvd >= 1000 && !busy) break;
            if (sent < 1000) begin
                in_vld = ($urandom_range(3, 0) != 0);
                in_data = $urandom;
            end else begin
                in_vld = 1'b0;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(in_data);
                sent++;
            end
            p_req = out_req;
            p_acks = ack_hist[NS-1];
            p_data = out_data;
            step();
            if (p_req || p_acks) chk("rand_data_stable", out_data, p_data);
            while (rx_q.size() > 0) begin
                got = rx_q.pop_front();
                recvd++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_word: got %0h expected no delivery", got);
                end else begin
                    chk("rand_scoreboard", got, exp_q.pop_front());
                end
            end
        end
        in_vld = 1'b0;
        chk("rand_sent", sent, 1000);
        chk("rand_recv", recvd, 1000);
        chk("rand_leftover", exp_q.size(), 0);
        chk("rand_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
